anim_frame_sequencer: RTL

//  Controller at the far end of the animation speed-counter interface. Reads the free-running

---
 rtl/anim_frame_sequencer.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/anim_frame_sequencer.sv
// anim_frame_sequencer: controls an external free-running speed counter through
// its active-low clear and count-enable lines. It emits a one-cycle tick and
// advances a sprite frame index each time the programmed period elapses.
// Build option ANIMSEQ_PINGPONG_EN: frames bounce 0..NUM_FRAMES-1..0 instead of wrapping.
module anim_frame_sequencer #(
    parameter int unsigned CNT_W      = 24,
    parameter int unsigned FRAME_W    = 3,
    parameter int unsigned NUM_FRAMES = 6,
    parameter int unsigned LOOP       = 1
) (
    input  logic               SC_ANIMSEQ_CLOCK_50,
    input  logic               SC_ANIMSEQ_RESET_InHigh,
    input  logic [CNT_W-1:0]   SC_ANIMSEQ_count_InBUS,
    input  logic [CNT_W-1:0]   SC_ANIMSEQ_period_InBUS,
    input  logic               SC_ANIMSEQ_start_InLow,
    input  logic               SC_ANIMSEQ_stop_InLow,
    output logic               SC_ANIMSEQ_clear_OutLow,
    output logic               SC_ANIMSEQ_upcount_OutLow,
    output logic [FRAME_W-1:0] SC_ANIMSEQ_frame_OutBUS,
    output logic               SC_ANIMSEQ_tick_Out,
    output logic               SC_ANIMSEQ_busy_Out,
    output logic               SC_ANIMSEQ_done_Out
);

    localparam logic [FRAME_W-1:0] LP_LAST = FRAME_W'(NUM_FRAMES - 1);
    localparam logic [FRAME_W-1:0] LP_ONE  = FRAME_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [FRAME_W-1:0] r_frame;
    logic [FRAME_W-1:0] w_frame_nxt;
    logic [FRAME_W-1:0] w_adv_frame;
    logic               w_adv_end;
    logic               r_clear_n;
    logic               r_upcount_n;
    logic               r_tick;
    logic               r_busy;
    logic               r_done;
    logic               w_clear_n_nxt;
    logic               w_upcount_n_nxt;
    logic               w_tick_nxt;
    logic               w_busy_nxt;
    logic               w_done_nxt;
    logic               w_start;
    logic               w_stop;
    logic [CNT_W-1:0]   w_thresh;
    logic               w_match;
`ifdef ANIMSEQ_PINGPONG_EN
    logic               r_dir_down;
    logic               w_dir_down_nxt;
    logic               w_adv_dir_down;
`endif

    assign w_start = !SC_ANIMSEQ_start_InLow;
    assign w_stop  = !SC_ANIMSEQ_stop_InLow;

    // Period 0 behaves as 1; a match is only honoured while the counter is not being cleared.
    assign w_thresh = (SC_ANIMSEQ_period_InBUS == '0) ? '0
                    : SC_ANIMSEQ_period_InBUS - CNT_W'(1);
    assign w_match  = (r_state == ST_RUN) && r_clear_n && (SC_ANIMSEQ_count_InBUS >= w_thresh);

    // Frame value and end-of-sequence flag that the next tick would produce.
    always_comb begin
        w_adv_frame = r_frame;
        w_adv_end   = 1'b0;
`ifdef ANIMSEQ_PINGPONG_EN
        w_adv_dir_down = r_dir_down;
        if (!r_dir_down) begin
            w_adv_frame = r_frame + LP_ONE;
            if (w_adv_frame == LP_LAST) begin
                w_adv_dir_down = 1'b1;
            end
        end else begin
            w_adv_frame = r_frame - LP_ONE;
            if (w_adv_frame == '0) begin
                w_adv_dir_down = 1'b0;
                w_adv_end      = (LOOP == 0);
            end
        end
`else
        if (r_frame == LP_LAST) begin
            if (LOOP != 0) begin
                w_adv_frame = '0;
            end else begin
                w_adv_end = 1'b1;
            end
        end else begin
            w_adv_frame = r_frame + LP_ONE;
        end
`endif
    end

    // State register plus the registered outputs loaded with the values of the entered state.
    always_ff @(posedge SC_ANIMSEQ_CLOCK_50 or posedge SC_ANIMSEQ_RESET_InHigh) begin
        if (SC_ANIMSEQ_RESET_InHigh) begin
            r_state     <= ST_IDLE;
            r_frame     <= '0;
            r_clear_n   <= 1'b0;
            r_upcount_n <= 1'b1;
            r_tick      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
`ifdef ANIMSEQ_PINGPONG_EN
            r_dir_down  <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_frame     <= w_frame_nxt;
            r_clear_n   <= w_clear_n_nxt;
            r_upcount_n <= w_upcount_n_nxt;
            r_tick      <= w_tick_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
`ifdef ANIMSEQ_PINGPONG_EN
            r_dir_down  <= w_dir_down_nxt;
`endif
        end
    end

    // Next-state logic; stop has priority over start, start is ignored while running.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_start && !w_stop) w_state_nxt = ST_CLEAR;
            ST_CLEAR: w_state_nxt = w_stop ? ST_IDLE : ST_RUN;
            ST_RUN: begin
                if (w_stop) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_match && w_adv_end) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (w_stop) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_start) begin
                    w_state_nxt = ST_CLEAR;
                end
            end
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Output values for the state being entered; a match pulses tick and clears the counter.
    always_comb begin
        w_frame_nxt     = r_frame;
        w_clear_n_nxt   = 1'b0;
        w_upcount_n_nxt = 1'b1;
        w_tick_nxt      = 1'b0;
        w_busy_nxt      = 1'b0;
        w_done_nxt      = 1'b0;
`ifdef ANIMSEQ_PINGPONG_EN
        w_dir_down_nxt  = r_dir_down;
`endif
        case (w_state_nxt)
            ST_CLEAR: begin
                w_frame_nxt = '0;
                w_busy_nxt  = 1'b1;
`ifdef ANIMSEQ_PINGPONG_EN
                w_dir_down_nxt = 1'b0;
`endif
            end
            ST_RUN: begin
                w_busy_nxt      = 1'b1;
                w_upcount_n_nxt = 1'b0;
                w_clear_n_nxt   = !w_match;
                if (w_match) begin
                    w_tick_nxt  = 1'b1;
                    w_frame_nxt = w_adv_frame;
`ifdef ANIMSEQ_PINGPONG_EN
                    w_dir_down_nxt = w_adv_dir_down;
`endif
                end
            end
            ST_DONE: begin
                w_done_nxt    = 1'b1;
                w_clear_n_nxt = 1'b1;
                if (w_match) begin
                    w_tick_nxt  = 1'b1;
                    w_frame_nxt = w_adv_frame;
`ifdef ANIMSEQ_PINGPONG_EN
                    w_dir_down_nxt = w_adv_dir_down;
`endif
                end
            end
            default: ;
        endcase
    end

    assign SC_ANIMSEQ_clear_OutLow   = r_clear_n;
    assign SC_ANIMSEQ_upcount_OutLow = r_upcount_n;
    assign SC_ANIMSEQ_frame_OutBUS   = r_frame;
    assign SC_ANIMSEQ_tick_Out       = r_tick;
    assign SC_ANIMSEQ_busy_Out       = r_busy;
    assign SC_ANIMSEQ_done_Out       = r_done;

endmodule
